// File: rtl/ray_dispatcher_if.sv
// Dispatcher-to-ray-core pixel bus: per-core ready/valid plus the shared pixel coordinate.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif
`ifndef H_BITS
`define H_BITS 9
`endif
`ifndef V_BITS
`define V_BITS 8
`endif

interface ray_dispatcher_if #(
  parameter int NUM_CORES = 4,
  parameter int H_BITS    = `H_BITS,
  parameter int V_BITS    = `V_BITS
);
  logic [NUM_CORES-1:0] cores_ready_in;
  logic [NUM_CORES-1:0] valid_out;
  logic [H_BITS-1:0]    hcount_out;
  logic [V_BITS-1:0]    vcount_out;

  modport master (input cores_ready_in, output valid_out, hcount_out, vcount_out);
  modport slave  (output cores_ready_in, input valid_out, hcount_out, vcount_out);
endinterface

// File: rtl/ray_dispatcher.sv
// Raster-order pixel dispatcher: hands one coordinate per cycle to ready ray cores, round-robin,
// and pulses frame_done once every pixel is issued and all cores are idle again.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif
`ifndef H_BITS
`define H_BITS 9
`endif
`ifndef V_BITS
`define V_BITS 8
`endif

module ray_dispatcher_lane (
  input  logic clk_in,
  input  logic rst_in,
  input  logic grant_in,
  input  logic ready_in,
  output logic valid_out,
  output logic holdoff_out,
  output logic eligible_out
);
  // A core only sees valid one edge after we raise it, so its ready is stale for that cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      valid_out   <= 1'b0;
      holdoff_out <= 1'b0;
    end else begin
      valid_out   <= grant_in;
      holdoff_out <= grant_in;
    end
  end

  assign eligible_out = ready_in & ~holdoff_out;
endmodule

module ray_dispatcher #(
  parameter int NUM_CORES      = 4,
  parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
  parameter int H_BITS         = `H_BITS,
  parameter int V_BITS         = `V_BITS
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  ray_dispatcher_if.master    cores,
  output logic                frame_busy_out,
  output logic                frame_done_out
);
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t               state;
  logic [PW-1:0]        ptr;
  logic [H_BITS-1:0]    scan_h, hcount_q;
  logic [V_BITS-1:0]    scan_v, vcount_q;
  logic [NUM_CORES-1:0] holdoff, eligible, grant_oh, lane_grant, valid_vec;
  logic [PW-1:0]        grant_idx, ptr_next;
  logic                 grant_any, last_pixel, line_end;

  // First eligible core at or after ptr; scanning downward lets the lowest offset win.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NUM_CORES; i++)
      grant_oh[i] = grant_any && (grant_idx == PW'(i));
  end

  assign lane_grant = (state == ISSUE) ? grant_oh : '0;
  assign ptr_next   = (grant_idx == PW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
  assign line_end   = (scan_h == H_BITS'(DISPLAY_WIDTH - 1));
  assign last_pixel = line_end && (scan_v == V_BITS'(DISPLAY_HEIGHT - 1));

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
    ray_dispatcher_lane u_lane (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .grant_in    (lane_grant[i]),
      .ready_in    (cores.cores_ready_in[i]),
      .valid_out   (valid_vec[i]),
      .holdoff_out (holdoff[i]),
      .eligible_out(eligible[i])
    );
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      ptr            <= '0;
      scan_h         <= '0;
      scan_v         <= '0;
      hcount_q       <= '0;
      vcount_q       <= '0;
      frame_busy_out <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      frame_done_out <= 1'b0;
      case (state)
        IDLE: if (start_in) begin
          state          <= ISSUE;
          frame_busy_out <= 1'b1;
          scan_h         <= '0;
          scan_v         <= '0;
        end
        ISSUE: if (grant_any) begin
          hcount_q <= scan_h;
          vcount_q <= scan_v;
          ptr      <= ptr_next;
          if (last_pixel) begin
            state <= DRAIN;
          end else if (line_end) begin
            scan_h <= '0;
            scan_v <= scan_v + 1'b1;
          end else begin
            scan_h <= scan_h + 1'b1;
          end
        end
        DRAIN: if ((&cores.cores_ready_in) && (holdoff == '0)) begin
          state          <= DONE;
          frame_done_out <= 1'b1;
          frame_busy_out <= 1'b0;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cores.valid_out  = valid_vec;
  assign cores.hcount_out = hcount_q;
  assign cores.vcount_out = vcount_q;
endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench: one 4-core and one 1-core dispatcher on a 4x2 display.
module tb_ray_dispatcher;
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in, start1, start4, busy1, done1, busy4, done4;
  int   checks = 0, errors = 0;
  int   done1_cnt = 0, done4_cnt = 0;
  logic [1:0] cnt1;

  ray_dispatcher_if #(.NUM_CORES(1), .H_BITS(4), .V_BITS(4)) bus1();
  ray_dispatcher_if #(.NUM_CORES(4), .H_BITS(4), .V_BITS(4)) bus4();

  ray_dispatcher #(.NUM_CORES(1), .DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(2), .H_BITS(4), .V_BITS(4)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start1), .cores(bus1),
    .frame_busy_out(busy1), .frame_done_out(done1));

  ray_dispatcher #(.NUM_CORES(4), .DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(2), .H_BITS(4), .V_BITS(4)) dut4 (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start4), .cores(bus4),
    .frame_busy_out(busy4), .frame_done_out(done4));

  // Single-core model: busy for three cycles after it samples valid.
  always @(posedge clk_in) begin
    if (!rst_in) begin
      bus1.cores_ready_in <= 1'b1;
      cnt1 <= 2'd0;
    end else if (bus1.valid_out[0]) begin
      bus1.cores_ready_in <= 1'b0;
      cnt1 <= 2'd2;
    end else if (!bus1.cores_ready_in[0]) begin
      if (cnt1 == 2'd0) bus1.cores_ready_in <= 1'b1;
      else cnt1 <= cnt1 - 2'd1;
    end
  end

  always @(negedge clk_in) begin
    if (done4) done4_cnt++;
    if (done1) done1_cnt++;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input int v, input int h, input int vv, input int b, input int d);
    check({tag, "_valid"}, 32'(bus4.valid_out), 32'(v));
    check({tag, "_h"}, 32'(bus4.hcount_out), 32'(h));
    check({tag, "_v"}, 32'(bus4.vcount_out), 32'(vv));
    check({tag, "_busy"}, 32'(busy4), 32'(b));
    check({tag, "_done"}, 32'(done4), 32'(d));
  endtask

  initial begin
    int a_valid[8] = '{1, 2, 4, 8, 1, 2, 4, 8};
    int b_valid[8] = '{1, 2, 8, 1, 2, 4, 8, 1};
    int w;
    rst_in = 1'b0; start1 = 1'b0; start4 = 1'b0;
    bus4.cores_ready_in = 4'hF;
    repeat (2) step();
    chk4("rst", 0, 0, 0, 0, 0);
    check("rst_d1_valid", 32'(bus1.valid_out), 32'd0);
    check("rst_d1_busy", 32'(busy1), 32'd0);
    rst_in = 1'b1;

    // All cores ready: strict rotation, start pulses during ISSUE and DONE ignored
    start4 = 1'b1; step(); start4 = 1'b0;
    chk4("a_start", 0, 0, 0, 1, 0);
    for (int p = 0; p < 8; p++) begin
      if (p == 2) start4 = 1'b1;
      step(); start4 = 1'b0;
      chk4($sformatf("a_grant%0d", p), a_valid[p], p % 4, p / 4, 1, 0);
    end
    step(); chk4("a_drain", 0, 3, 1, 1, 0);
    step(); chk4("a_done", 0, 3, 1, 0, 1);
    start4 = 1'b1; step(); start4 = 1'b0;
    chk4("a_idle", 0, 3, 1, 0, 0);
    step(); chk4("a_idle2", 0, 3, 1, 0, 0);
    check("a_done_cnt", 32'(done4_cnt), 32'd1);

    // Core 2 held off, released when the pointer reaches it; slow drain
    bus4.cores_ready_in = 4'b1011;
    start4 = 1'b1; step(); start4 = 1'b0;
    chk4("b_start", 0, 3, 1, 1, 0);
    for (int p = 0; p < 8; p++) begin
      step();
      chk4($sformatf("b_grant%0d", p), b_valid[p], p % 4, p / 4, 1, 0);
      if (p == 4) bus4.cores_ready_in = 4'hF;
    end
    bus4.cores_ready_in = 4'b0001;
    step(); chk4("b_drain1", 0, 3, 1, 1, 0);
    step(); chk4("b_drain2", 0, 3, 1, 1, 0);
    bus4.cores_ready_in = 4'b0111;
    step(); chk4("b_drain3", 0, 3, 1, 1, 0);
    bus4.cores_ready_in = 4'hF;
    step(); chk4("b_done", 0, 3, 1, 0, 1);
    step(); chk4("b_idle", 0, 3, 1, 0, 0);
    check("b_done_cnt", 32'(done4_cnt), 32'd2);

    // Single core with three-cycle latency
    start1 = 1'b1; step(); start1 = 1'b0;
    check("s_busy", 32'(busy1), 32'd1);
    for (int p = 0; p < 8; p++) begin
      w = 0;
      do begin step(); w++; end while (!bus1.valid_out[0] && w < 20);
      check($sformatf("s_gap%0d", p), 32'(w), (p == 0) ? 32'd1 : 32'd5);
      check($sformatf("s_h%0d", p), 32'(bus1.hcount_out), 32'(p % 4));
      check($sformatf("s_v%0d", p), 32'(bus1.vcount_out), 32'(p / 4));
    end
    w = 0;
    do begin step(); w++; end while (!done1 && w < 20);
    check("s_done_gap", 32'(w), 32'd5);
    check("s_done_busy", 32'(busy1), 32'd0);
    step();
    check("s_done_cnt", 32'(done1_cnt), 32'd1);

    // Reset at the third grant, then a fresh frame starts at (0,0) on core 0
    start4 = 1'b1; step(); start4 = 1'b0;
    step(); chk4("c_grant0", 2, 0, 0, 1, 0);
    step(); chk4("c_grant1", 4, 1, 0, 1, 0);
    step(); chk4("c_grant2", 8, 2, 0, 1, 0);
    rst_in = 1'b0;
    step(); chk4("c_rst", 0, 0, 0, 0, 0);
    rst_in = 1'b1;
    step(); chk4("c_rst_idle", 0, 0, 0, 0, 0);
    start4 = 1'b1; step(); start4 = 1'b0;
    chk4("c_restart", 0, 0, 0, 1, 0);
    step(); chk4("c_first", 1, 0, 0, 1, 0);
    step(); chk4("c_second", 2, 1, 0, 1, 0);
    check("c_done_cnt", 32'(done4_cnt), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
